irq_controller: RTL and testbench
=================================

Name: irq_controller

Overview:
- Parametrised interrupt controller. Generalises the fixed IE-access/ALU steering logic into a complete block.
- Holds the IE and IF registers, the master enable (IME) and a delayed-EI counter.
- Prioritises pending requests and runs a request/acknowledge dispatch handshake with the CPU sequencer, returning a restart vector.
- Sits between the decoder/sequencer (top) and the bus/register file (bottom). Also drives HALT wake-up.

Parameters:
- NUM_IRQ, 5, number of interrupt channels (1..8); channel 0 has highest priority.
- IE_ADDR, 16'hFFFF, IE register address.
- IF_ADDR, 16'hFF0F, IF register address.
- VEC_BASE, 8'h40, vector of channel 0.
- VEC_STRIDE, 8, vector spacing between channels.
- EI_DELAY, 1, cycles between the ei pulse and IME becoming 1 (0..3).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- nRESET  in  1  synchronous, active-low reset.
- A  in  16  bus address.
- D_in  in  8  write data (DL bus).
- D_out  out  8  read data; valid when sel=1.
- RD  in  1  read strobe.
- WR  in  1  write strobe.
- sel  out  1  combinational: A equals IE_ADDR or IF_ADDR.
- irq_req  in  NUM_IRQ  level request lines from peripherals.
- ei  in  1  one-cycle pulse: enable interrupts.
- di  in  1  one-cycle pulse: disable interrupts.
- int_ack  in  1  CPU accepts the pending dispatch.
- int_req  out  1  dispatch request to the sequencer.
- vector  out  8  restart address, low byte.
- vec_valid  out  1  vector valid, one-cycle pulse.
- ime  out  1  current master enable.
- wake  out  1  combinational: |(IE[NUM_IRQ-1:0] & IF), independent of IME.

Behaviour:
- Interface: one clock CLK; reset nRESET is synchronous and active-low.
- Reset (nRESET=0 at a clock edge):
  - IE=8'h00, IF=0, IME=0, EI counter=0, FSM=IDLE.
  - int_req=0, vec_valid=0, vector=8'h00.
  - Input edge-detect history=0.
  - Reset mid-dispatch aborts it: no vec_valid and no IF clear.
- IE register: full 8 bits stored. WR with A==IE_ADDR loads D_in next edge. Reads return all 8 bits.
- IF register: NUM_IRQ bits.
  - A rising edge on irq_req[i] (registered history) sets IF[i].
  - WR with A==IF_ADDR loads D_in[NUM_IRQ-1:0].
  - Reads return unimplemented upper bits as 1.
  - Same-edge conflict on one bit: hardware set > dispatch clear > CPU write.
- D_out: the selected register, otherwise 8'hFF.
- IME:
  - di clears IME next edge and cancels any running EI countdown.
  - ei loads the counter with EI_DELAY. IME becomes 1 when the counter reaches 0; with EI_DELAY=0, IME=1 next edge.
  - ei and di in the same cycle: di wins.
  - Repeated ei while counting restarts the count.
- pend = IME & |(IE[NUM_IRQ-1:0] & IF).
- FSM:
  - IDLE: when pend, go to PEND and set int_req=1 (1-cycle latency from pend).
  - PEND: int_req held at 1.
    - If pend drops and no int_ack: go to IDLE, int_req=0.
    - On int_ack (ack wins over a same-cycle drop):
      - Sample m = IE & IF at that edge.
      - k = lowest set index of m.
      - vector = VEC_BASE + k*VEC_STRIDE (8-bit wrap).
      - Clear IF[k] and IME. Go to VEC.
      - If m==0 (cleared meanwhile): vector=8'h00, no IF clear, IME still cleared.
  - VEC: vec_valid=1 for exactly one cycle, int_req=0, vector held. Next state IDLE.
  - vector holds its last value until the next dispatch.
  - int_ack outside PEND is ignored.

Decomposition:
- Shared package irq_pkg:
  - FSM state enum (IDLE, PEND, VEC).
  - Default IE/IF addresses.
  - Vector base and stride.
  - A function for the lowest-set-bit index.
- One sub-module, irq_prio_enc: parametrised priority encoder (NUM_IRQ in; index plus any-flag out).

Test Plan:
- Reset, then read IF with NUM_IRQ=5 -> D_out=8'hE0. Read IE -> 8'h00. int_req=0, ime=0.
- IE=8'h04, ei (EI_DELAY=1), irq_req[2] rises -> IME=1 after 1 cycle. int_req the cycle after pend. On int_ack: vector=8'h50, vec_valid pulses once, IF[2]=0, ime=0.
- IE=8'h1F, irq_req[4] and irq_req[1] rise together, IME=1 -> first dispatch vector=8'h48, IF=5'b10000. After ei, second dispatch vector=8'h60.
- In PEND, CPU writes IE=8'h00 one cycle before int_ack -> vector=8'h00, vec_valid=1, IF unchanged, ime=0.
- ei and di in the same cycle -> ime stays 0. irq_req edge on a bit in the same cycle as a CPU write of IF=0 -> that bit reads 1.
- Hold nRESET=0 for one edge while in PEND -> int_req=0, no vec_valid, IF=0, FSM=IDLE.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller slice.
// Holds the dispatch FSM states, default register map and the lowest-set-bit helper.
package irq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_VEC  = 2'd2
   } irq_state_e;

   localparam logic [15:0] IRQ_IE_ADDR    = 16'hFFFF;
   localparam logic [15:0] IRQ_IF_ADDR    = 16'hFF0F;
   localparam logic [7:0]  IRQ_VEC_BASE   = 8'h40;
   localparam int unsigned IRQ_VEC_STRIDE = 8;

   // Bit 0 is the highest priority, so the lowest set index wins.
   function automatic logic [2:0] lowest_set_idx(input logic [7:0] v);
      logic [2:0] idx;
      logic       found;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (v[i] && !found) begin
            idx   = 3'(i);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Parametrised priority encoder: index of the lowest set request plus an any-request flag.
module irq_prio_enc
   import irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 5
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic [2:0]         idx_o,
   output logic               any_o
);

   logic [7:0] padded;

   always_comb begin
      padded              = '0;
      padded[NUM_IRQ-1:0] = req_i;
   end

   assign idx_o = lowest_set_idx(padded);
   assign any_o = |req_i;

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: IE/IF registers, master enable with delayed EI, and the
// request/acknowledge dispatch handshake that returns a restart vector.
module irq_controller
   import irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ    = 5,
   parameter logic [15:0] IE_ADDR    = IRQ_IE_ADDR,
   parameter logic [15:0] IF_ADDR    = IRQ_IF_ADDR,
   parameter logic [7:0]  VEC_BASE   = IRQ_VEC_BASE,
   parameter int unsigned VEC_STRIDE = IRQ_VEC_STRIDE,
   parameter int unsigned EI_DELAY   = 1
) (
   input  logic               CLK,
   input  logic               nRESET,
   input  logic [15:0]        A,
   input  logic [7:0]         D_in,
   output logic [7:0]         D_out,
   input  logic               RD,
   input  logic               WR,
   output logic               sel,
   input  logic [NUM_IRQ-1:0] irq_req,
   input  logic               ei,
   input  logic               di,
   input  logic               int_ack,
   output logic               int_req,
   output logic [7:0]         vector,
   output logic               vec_valid,
   output logic               ime,
   output logic               wake
);

   logic [7:0]         ie_q, ie_d;
   logic [NUM_IRQ-1:0] if_q, if_d;
   logic [NUM_IRQ-1:0] hist_q;
   logic               ime_q, ime_d;
   logic [1:0]         cnt_q, cnt_d;
   logic [7:0]         vec_q, vec_d;
   irq_state_e         state_q, state_d;

   logic               hit_ie, hit_if;
   logic [NUM_IRQ-1:0] masked, rise, clr_mask;
   logic [2:0]         win_idx;
   logic               win_any;
   logic               pend, dispatch;
   logic [7:0]         vec_calc;
   logic [7:0]         if_rd;

   assign hit_ie = (A == IE_ADDR);
   assign hit_if = (A == IF_ADDR);
   assign sel    = hit_ie | hit_if;

   assign masked = ie_q[NUM_IRQ-1:0] & if_q;
   assign wake   = |masked;
   assign pend   = ime_q & wake;
   assign rise   = irq_req & ~hist_q;

   irq_prio_enc #(
      .NUM_IRQ (NUM_IRQ)
   ) u_prio (
      .req_i (masked),
      .idx_o (win_idx),
      .any_o (win_any)
   );

   assign dispatch = (state_q == ST_PEND) && int_ack;
   assign vec_calc = VEC_BASE + 8'(32'(win_idx) * VEC_STRIDE);
   assign clr_mask = (dispatch && win_any) ? (NUM_IRQ'(1) << win_idx) : '0;

   always_comb begin
      if_rd              = '1;
      if_rd[NUM_IRQ-1:0] = if_q;
      D_out              = 8'hFF;
      if (RD) begin
         if (hit_ie)      D_out = ie_q;
         else if (hit_if) D_out = if_rd;
      end
   end

   // Applied in reverse priority: CPU write, then dispatch clear, then hardware set.
   always_comb begin
      ie_d = (WR && hit_ie) ? D_in : ie_q;
      if_d = (WR && hit_if) ? D_in[NUM_IRQ-1:0] : if_q;
      if_d = (if_d & ~clr_mask) | rise;
   end

   // A fresh ei restarts the countdown, so it must not also take a completing count.
   always_comb begin
      ime_d = ime_q;
      cnt_d = cnt_q;
      if (ei) begin
         if (EI_DELAY == 0) ime_d = 1'b1;
         else               cnt_d = 2'(EI_DELAY);
      end else if (cnt_q != 2'd0) begin
         cnt_d = cnt_q - 2'd1;
         if (cnt_q == 2'd1) ime_d = 1'b1;
      end
      if (di) begin
         ime_d = 1'b0;
         cnt_d = 2'd0;
      end
      if (dispatch) ime_d = 1'b0;
   end

   always_comb begin
      vec_d = vec_q;
      if (dispatch) vec_d = win_any ? vec_calc : 8'h00;
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         ie_q   <= '0;
         if_q   <= '0;
         hist_q <= '0;
         ime_q  <= 1'b0;
         cnt_q  <= 2'd0;
         vec_q  <= 8'h00;
      end else begin
         ie_q   <= ie_d;
         if_q   <= if_d;
         hist_q <= irq_req;
         ime_q  <= ime_d;
         cnt_q  <= cnt_d;
         vec_q  <= vec_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRESET) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // Acknowledge takes precedence over pend dropping in the same cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (pend) state_d = ST_PEND;
         ST_PEND: begin
            if (int_ack)    state_d = ST_VEC;
            else if (!pend) state_d = ST_IDLE;
         end
         ST_VEC:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      int_req   = (state_q == ST_PEND);
      vec_valid = (state_q == ST_VEC);
   end

   assign vector = vec_q;
   assign ime    = ime_q;

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: a per-cycle reference model predicts outputs,
// a monitor compares them and pops expected vectors whenever vec_valid pulses.
module tb_irq_controller;

   localparam int unsigned N        = 5;
   localparam logic [15:0] IEA      = 16'hFFFF;
   localparam logic [15:0] IFA      = 16'hFF0F;
   localparam int unsigned EI_DLY   = 1;

   logic          CLK;
   logic          nRESET;
   logic [15:0]   A;
   logic [7:0]    D_in, D_out, vector;
   logic          RD, WR, sel, ei, di, int_ack, int_req, vec_valid, ime, wake;
   logic [N-1:0]  irq_req;

   irq_controller #(
      .NUM_IRQ    (N),
      .IE_ADDR    (IEA),
      .IF_ADDR    (IFA),
      .VEC_BASE   (8'h40),
      .VEC_STRIDE (8),
      .EI_DELAY   (EI_DLY)
   ) dut (
      .CLK       (CLK),
      .nRESET    (nRESET),
      .A         (A),
      .D_in      (D_in),
      .D_out     (D_out),
      .RD        (RD),
      .WR        (WR),
      .sel       (sel),
      .irq_req   (irq_req),
      .ei        (ei),
      .di        (di),
      .int_ack   (int_ack),
      .int_req   (int_req),
      .vector    (vector),
      .vec_valid (vec_valid),
      .ime       (ime),
      .wake      (wake)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       int_req;
      logic       vec_valid;
      logic       ime;
      logic       wake;
      logic       sel;
      logic [7:0] dout;
      logic [7:0] vector;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] vec_q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   bit         started = 0;

   // Reference model state (values visible during the current cycle)
   logic [7:0]   m_ie;
   logic [N-1:0] m_if, m_hist;
   logic         m_ime, m_req, m_vv;
   logic [7:0]   m_vec;
   int           m_cyc;
   int           m_due;

   // Next stimulus
   logic         s_rst;
   logic [15:0]  s_a;
   logic [7:0]   s_d;
   logic         s_rd, s_wr, s_ei, s_di, s_ack;
   logic [N-1:0] s_irq;

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_step();
      exp_t         e;
      logic [N-1:0] rise, andv, n_if;
      logic         pend, ack_now, n_ime, n_req;
      int           k;
      if (!s_rst) begin
         m_ie = 8'h00; m_if = '0; m_hist = '0; m_ime = 1'b0;
         m_req = 1'b0; m_vv = 1'b0; m_vec = 8'h00; m_due = -1;
      end else begin
         rise    = s_irq & ~m_hist;
         andv    = m_ie[N-1:0] & m_if;
         pend    = m_ime && (andv != '0);
         ack_now = m_req && s_ack;
         n_if    = (s_wr && s_a == IFA) ? s_d[N-1:0] : m_if;
         n_ime   = m_ime;
         if (ack_now) begin
            k = -1;
            for (int i = N - 1; i >= 0; i--) if (andv[i]) k = i;
            if (k >= 0) begin
               n_if[k] = 1'b0;
               m_vec   = 8'h40 + 8'(k * 8);
            end else begin
               m_vec   = 8'h00;
            end
            vec_q.push_back(m_vec);
         end
         n_if = n_if | rise;
         if (s_ei) begin
            if (EI_DLY == 0) n_ime = 1'b1;
            else             m_due = m_cyc + EI_DLY;
         end else if (m_due == m_cyc) begin
            n_ime = 1'b1;
            m_due = -1;
         end
         if (s_di) begin
            n_ime = 1'b0;
            m_due = -1;
         end
         if (ack_now) n_ime = 1'b0;
         n_req  = pend && (m_req ? !s_ack : !m_vv);
         m_vv   = ack_now;
         m_req  = n_req;
         m_ie   = (s_wr && s_a == IEA) ? s_d : m_ie;
         m_if   = n_if;
         m_ime  = n_ime;
         m_hist = s_irq;
      end
      m_cyc++;
      e.int_req   = m_req;
      e.vec_valid = m_vv;
      e.ime       = m_ime;
      e.wake      = (m_ie[N-1:0] & m_if) != '0;
      e.sel       = (s_a == IEA) || (s_a == IFA);
      e.dout      = 8'hFF;
      if (s_rd && s_a == IEA)      e.dout = m_ie;
      else if (s_rd && s_a == IFA) e.dout = {3'b111, m_if};
      e.vector    = m_vec;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(negedge CLK);
      nRESET  = s_rst;
      A       = s_a;
      D_in    = s_d;
      RD      = s_rd;
      WR      = s_wr;
      ei      = s_ei;
      di      = s_di;
      int_ack = s_ack;
      irq_req = s_irq;
      model_step();
      started = 1;
      s_wr = 0; s_ei = 0; s_di = 0; s_ack = 0; s_rst = 1;
   endtask

   task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
      s_a = a; s_d = d; s_wr = 1; tick();
   endtask

   task automatic wait_req_ack();
      for (int i = 0; i < 20 && !m_req; i++) tick();
      s_ack = 1;
      tick();
   endtask

   // Monitor: compares DUT outputs against the queued predictions.
   initial begin
      exp_t e;
      logic [7:0] v;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() == 0) begin
            if (started) begin
               n_vec++; n_bad++;
               $display("FAIL underflow: got DUT cycle expected queued prediction");
            end
         end else begin
            e = exp_q.pop_front();
            check8("int_req",   {7'd0, int_req},   {7'd0, e.int_req});
            check8("vec_valid", {7'd0, vec_valid}, {7'd0, e.vec_valid});
            check8("ime",       {7'd0, ime},       {7'd0, e.ime});
            check8("wake",      {7'd0, wake},      {7'd0, e.wake});
            check8("sel",       {7'd0, sel},       {7'd0, e.sel});
            check8("D_out",     D_out,             e.dout);
            check8("vector",    vector,            e.vector);
            if (vec_valid === 1'b1) begin
               if (vec_q.size() == 0) begin
                  n_vec++; n_bad++;
                  $display("FAIL vec_pulse: got vec_valid with vector %02h expected no dispatch", vector);
               end else begin
                  v = vec_q.pop_front();
                  check8("dispatch_vector", vector, v);
               end
            end
         end
      end
   end

   initial begin
      logic [N-1:0] flip;
      m_cyc = 0; m_due = -1;
      m_ie = '0; m_if = '0; m_hist = '0; m_ime = 0; m_req = 0; m_vv = 0; m_vec = '0;
      s_rst = 0; s_a = 16'h0000; s_d = 8'h00; s_rd = 0; s_wr = 0;
      s_ei = 0; s_di = 0; s_ack = 0; s_irq = '0;
      nRESET = 0; A = '0; D_in = '0; RD = 0; WR = 0; ei = 0; di = 0; int_ack = 0; irq_req = '0;

      // Reset and reset-value reads
      s_rst = 0; tick(); tick();
      s_a = IFA; s_rd = 1; tick();
      s_a = IEA; s_rd = 1; tick();

      // Single channel dispatch: vector 0x50
      write_reg(IEA, 8'h04);
      s_ei = 1; tick();
      s_irq = 5'b00100; tick();
      wait_req_ack();
      tick(); tick();
      s_a = IFA; tick();

      // Two simultaneous requests: 0x48 then 0x60
      s_irq = '0; tick();
      write_reg(IEA, 8'h1F);
      s_ei = 1; tick(); tick();
      s_irq = 5'b10010; tick();
      wait_req_ack();
      s_a = IFA; tick();
      s_ei = 1; tick();
      wait_req_ack();
      tick(); tick();

      // IE cleared while pending: vector 0x00, IF kept
      s_irq = '0; tick();
      write_reg(IEA, 8'h04);
      s_ei = 1; tick();
      s_irq = 5'b00100; tick();
      for (int i = 0; i < 20 && !m_req; i++) tick();
      write_reg(IEA, 8'h00);
      s_ack = 1; s_a = IFA; tick();
      tick(); tick();

      // ei and di together; hardware set beats CPU clear of IF
      s_ei = 1; s_di = 1; tick(); tick(); tick();
      s_irq = 5'b00000; tick();
      s_irq = 5'b00001; s_a = IFA; s_d = 8'h00; s_wr = 1; tick();
      s_a = IFA; tick();

      // Reset while pending
      write_reg(IEA, 8'h01);
      s_ei = 1; tick();
      for (int i = 0; i < 20 && !m_req; i++) tick();
      s_rst = 0; tick();
      s_a = IFA; tick(); tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s_rst = ($urandom_range(299) != 0);
         case ($urandom_range(3))
            0:       s_a = IEA;
            1:       s_a = IFA;
            2:       s_a = IFA;
            default: s_a = 16'($urandom);
         endcase
         s_d   = 8'($urandom);
         s_rd  = $urandom_range(1) == 1;
         s_wr  = $urandom_range(7) == 0;
         s_ei  = $urandom_range(7) == 0;
         s_di  = $urandom_range(24) == 0;
         s_ack = $urandom_range(2) == 0;
         flip  = N'($urandom & $urandom & $urandom);
         s_irq = s_irq ^ flip;
         tick();
      end

      s_rd = 0; s_a = 16'h0000; tick(); tick();
      @(posedge CLK);
      #3;
      n_vec++;
      if (exp_q.size() != 0 || vec_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d cycles and %0d vectors pending expected 0 and 0",
                  exp_q.size(), vec_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
